// File: rtl/rv32_pkg.sv
// Shared sizing constants for the RV32 register file and its write scoreboard.
package rv32_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int SB_CNT_W  = 2;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/rv32_sb_counter.sv
// Saturating pending-write counter for one architectural register.
module rv32_sb_counter
    import rv32_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // A simultaneous set and clear cancel out; clearing an idle counter is harmless.
    always_comb begin
        cnt_d    = cnt_q;
        overflow = 1'b0;
        if (set && !clr) begin
            if (cnt_q == CNT_MAX) begin
                overflow = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clr && !set && cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rv32_regfile.sv
// RV32 integer register file with write-through bypass and a per-register
// pending-write scoreboard for decode-stage hazard detection.
module rv32_regfile #(
    parameter int XLEN     = rv32_pkg::XLEN,
    parameter int NUM_REGS = rv32_pkg::NUM_REGS,
    parameter int SB_CNT_W = rv32_pkg::SB_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          regif_wb_enable,
    input  logic [rv32_pkg::REG_IDX_W-1:0] regif_wb_reg,
    input  logic [XLEN-1:0]               regif_wb_data,
    input  logic [rv32_pkg::REG_IDX_W-1:0] rs1_reg,
    input  logic [rv32_pkg::REG_IDX_W-1:0] rs2_reg,
    output logic [XLEN-1:0]               rs1_data,
    output logic [XLEN-1:0]               rs2_data,
    input  logic                          sb_set_enable,
    input  logic [rv32_pkg::REG_IDX_W-1:0] sb_set_reg,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          sb_overflow
);

    localparam int IDX_W = rv32_pkg::REG_IDX_W;
    localparam logic [IDX_W-1:0] X0 = '0;

    logic [XLEN-1:0]     regs_d [1:NUM_REGS-1];
    logic [XLEN-1:0]     regs_q [1:NUM_REGS-1];
    logic [SB_CNT_W-1:0] cnt    [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] ovf_pulse;
    logic                overflow_d;
    logic                overflow_q;
    logic                wb_hit1;
    logic                wb_hit2;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        rv32_sb_counter #(
            .CNT_W(SB_CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .set     (sb_set_enable && sb_set_reg == IDX_W'(r)),
            .clr     (regif_wb_enable && regif_wb_reg == IDX_W'(r)),
            .cnt     (cnt[r]),
            .overflow(ovf_pulse[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (regif_wb_enable && regif_wb_reg != X0) begin
            regs_d[regif_wb_reg] = regif_wb_data;
        end
        overflow_d = overflow_q | (|ovf_pulse);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q     <= '{default: '0};
            overflow_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            overflow_q <= overflow_d;
        end
    end

    assign wb_hit1 = regif_wb_enable && regif_wb_reg == rs1_reg;
    assign wb_hit2 = regif_wb_enable && regif_wb_reg == rs2_reg;

    // A count of one is retired by a WB to the same register this cycle, so only then is it not a hazard.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rs1_reg != X0) begin
            rs1_data = wb_hit1 ? regif_wb_data : regs_q[rs1_reg];
            rs1_busy = (cnt[rs1_reg] > SB_CNT_W'(1)) ||
                       (cnt[rs1_reg] == SB_CNT_W'(1) && !wb_hit1);
        end
        if (rs2_reg != X0) begin
            rs2_data = wb_hit2 ? regif_wb_data : regs_q[rs2_reg];
            rs2_busy = (cnt[rs2_reg] > SB_CNT_W'(1)) ||
                       (cnt[rs2_reg] == SB_CNT_W'(1) && !wb_hit2);
        end
    end

    assign sb_overflow = overflow_q;

endmodule

// File: tb/tb_rv32_regfile.sv
// Directed bench for rv32_regfile: behavioural reference checked every cycle
// plus hand-computed expectations for the key scenarios.
module tb_rv32_regfile;

    logic        clk;
    logic        reset;
    logic        regif_wb_enable;
    logic [4:0]  regif_wb_reg;
    logic [31:0] regif_wb_data;
    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        sb_set_enable;
    logic [4:0]  sb_set_reg;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        sb_overflow;

    int pass_count  = 0;
    int check_count = 0;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_ovf;

    rv32_regfile dut (
        .clk            (clk),
        .reset          (reset),
        .regif_wb_enable(regif_wb_enable),
        .regif_wb_reg   (regif_wb_reg),
        .regif_wb_data  (regif_wb_data),
        .rs1_reg        (rs1_reg),
        .rs2_reg        (rs2_reg),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .sb_set_enable  (sb_set_enable),
        .sb_set_reg     (sb_set_reg),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .sb_overflow    (sb_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    // Reference: a read sees the WB data if it targets the same nonzero register.
    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (regif_wb_enable && regif_wb_reg == r) return regif_wb_data;
        return m_regs[r];
    endfunction

    function automatic logic model_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_cnt[r] >= 2) return 1'b1;
        if (m_cnt[r] == 1 && !(regif_wb_enable && regif_wb_reg == r)) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_cnt[i]  = 0;
        end
        m_ovf = 1'b0;
    end

    always @(negedge reset) begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] <= 32'h0;
            m_cnt[i]  <= 0;
        end
        m_ovf <= 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                automatic logic s = sb_set_enable && sb_set_reg == 5'(i);
                automatic logic c = regif_wb_enable && regif_wb_reg == 5'(i);
                if (s && !c) begin
                    if (m_cnt[i] == 3) m_ovf <= 1'b1;
                    else m_cnt[i] <= m_cnt[i] + 1;
                end else if (c && !s && m_cnt[i] > 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end
            end
            if (regif_wb_enable && regif_wb_reg != 5'd0) m_regs[regif_wb_reg] <= regif_wb_data;
        end
    end

    always @(negedge clk) begin
        check_output("cyc_rs1_data", rs1_data, model_read(rs1_reg));
        check_output("cyc_rs2_data", rs2_data, model_read(rs2_reg));
        check_output("cyc_rs1_busy", 32'(rs1_busy), 32'(model_busy(rs1_reg)));
        check_output("cyc_rs2_busy", 32'(rs2_busy), 32'(model_busy(rs2_reg)));
        check_output("cyc_overflow", 32'(sb_overflow), 32'(m_ovf));
    end

    task automatic apply_stimulus(input logic wb_en, input logic [4:0] wb_reg, input logic [31:0] wb_data,
                                  input logic set_en, input logic [4:0] set_reg,
                                  input logic [4:0] r1, input logic [4:0] r2);
        regif_wb_enable = wb_en;
        regif_wb_reg    = wb_reg;
        regif_wb_data   = wb_data;
        sb_set_enable   = set_en;
        sb_set_reg      = set_reg;
        rs1_reg         = r1;
        rs2_reg         = r2;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        regif_wb_enable = 1'b0;
        regif_wb_reg    = 5'd0;
        regif_wb_data   = 32'h0;
        sb_set_enable   = 1'b0;
        sb_set_reg      = 5'd0;
        rs1_reg         = 5'd1;
        rs2_reg         = 5'd2;
        #2 reset = 1'b0;
        #1;
        check_output("reset_rs1_data", rs1_data, 32'h0);
        check_output("reset_busy", 32'(rs1_busy), 32'h0);
        check_output("reset_overflow", 32'(sb_overflow), 32'h0);
        #9 reset = 1'b1;
        next_cycle();

        // Write x5 with same-cycle bypass, then a registered read.
        apply_stimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0);
        check_output("x5_bypass", rs1_data, 32'hDEADBEEF);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd0);
        check_output("x5_read", rs1_data, 32'hDEADBEEF);
        next_cycle();

        apply_stimulus(1, 5'd7, 32'h12345678, 0, 5'd0, 5'd0, 5'd7);
        check_output("x7_bypass", rs2_data, 32'h12345678);
        next_cycle();
        apply_stimulus(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 5'd7);
        check_output("x0_bypass_blocked", rs1_data, 32'h0);
        check_output("x7_read", rs2_data, 32'h12345678);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
        check_output("x0_after_write", rs1_data, 32'h0);
        check_output("x0_set_busy", 32'(rs1_busy), 32'h0);
        next_cycle();

        // Two sets on x3, then two retiring writes.
        apply_stimulus(0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd0);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd0);
        check_output("x3_cnt1_busy", 32'(rs1_busy), 32'h1);
        next_cycle();
        apply_stimulus(1, 5'd3, 32'h0000000A, 0, 5'd0, 5'd3, 5'd0);
        check_output("x3_cnt2_wb_busy", 32'(rs1_busy), 32'h1);
        next_cycle();
        apply_stimulus(1, 5'd3, 32'h0000000B, 0, 5'd0, 5'd3, 5'd0);
        check_output("x3_cnt1_wb_busy", 32'(rs1_busy), 32'h0);
        check_output("x3_cnt1_wb_data", rs1_data, 32'h0000000B);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd0);
        check_output("x3_cnt0_busy", 32'(rs1_busy), 32'h0);
        next_cycle();

        // Set and WB on x9 in the same cycle leave the count at one.
        apply_stimulus(0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0);
        next_cycle();
        apply_stimulus(1, 5'd9, 32'h00000099, 1, 5'd9, 5'd9, 5'd0);
        check_output("x9_setclr_busy", 32'(rs1_busy), 32'h0);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
        check_output("x9_after_busy", 32'(rs1_busy), 32'h1);
        next_cycle();
        apply_stimulus(1, 5'd9, 32'h00000099, 0, 5'd0, 5'd0, 5'd0);
        next_cycle();

        // Saturate x4 and overflow.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 5'd0, 32'h0, 1, 5'd4, 5'd4, 5'd0);
            if (i == 3) check_output("x4_ovf_before_4th", 32'(sb_overflow), 32'h0);
            next_cycle();
        end
        apply_stimulus(1, 5'd4, 32'h00000044, 0, 5'd0, 5'd4, 5'd0);
        check_output("x4_overflow", 32'(sb_overflow), 32'h1);
        check_output("x4_cnt3_wb_busy", 32'(rs1_busy), 32'h1);
        next_cycle();
        apply_stimulus(1, 5'd4, 32'h00000045, 0, 5'd0, 5'd4, 5'd0);
        check_output("x4_cnt2_wb_busy", 32'(rs1_busy), 32'h1);
        check_output("x4_overflow_sticky", 32'(sb_overflow), 32'h1);
        next_cycle();
        apply_stimulus(1, 5'd4, 32'h00000046, 0, 5'd0, 5'd4, 5'd0);
        next_cycle();
        apply_stimulus(1, 5'd4, 32'h00000047, 0, 5'd0, 5'd4, 5'd0);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd0);
        check_output("x4_clr_at_zero_busy", 32'(rs1_busy), 32'h0);
        check_output("x4_final_data", rs1_data, 32'h00000047);
        next_cycle();

        // Fill every register, mark x6 pending, then reset mid-cycle.
        for (int r = 1; r < 32; r++) begin
            apply_stimulus(1, 5'(r), 32'h01010101 * 32'(r), 0, 5'd0, 5'd0, 5'd0);
            next_cycle();
        end
        apply_stimulus(0, 5'd0, 32'h0, 1, 5'd6, 5'd0, 5'd0);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd6);
        check_output("pre_reset_x5", rs1_data, 32'h05050505);
        check_output("pre_reset_x6_busy", 32'(rs2_busy), 32'h1);
        reset = 1'b0;
        #1;
        check_output("async_reset_x5", rs1_data, 32'h0);
        check_output("async_reset_x6", rs2_data, 32'h0);
        check_output("async_reset_busy", 32'(rs2_busy), 32'h0);
        check_output("async_reset_ovf", 32'(sb_overflow), 32'h0);
        apply_stimulus(1, 5'd10, 32'h00001234, 1, 5'd6, 5'd10, 5'd6);
        check_output("reset_bypass_x10", rs1_data, 32'h00001234);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd10, 5'd6);
        reset = 1'b1;
        next_cycle();
        check_output("reset_lost_write", rs1_data, 32'h0);
        check_output("reset_lost_set", 32'(rs2_busy), 32'h0);
        apply_stimulus(1, 5'd10, 32'hCAFEF00D, 0, 5'd0, 5'd10, 5'd6);
        next_cycle();
        apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 5'd10, 5'd6);
        check_output("post_reset_write", rs1_data, 32'hCAFEF00D);
        next_cycle();
        next_cycle();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/rv32_regfile.md
RV32_REGFILE -- requirements
Module: rv32_regfile

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, 32, datapath width.
- NUM_REGS, 32, architectural registers x0..x31.
- SB_CNT_W, 2, width of each per-register pending-write counter.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- regif_wb_enable  input  1  write strobe from the writeback stage.
- regif_wb_reg  input  5  destination register of the write.
- regif_wb_data  input  XLEN  write data.
- rs1_reg  input  5  decode-stage source register 1.
- rs2_reg  input  5  decode-stage source register 2.
- rs1_data  output  XLEN  read data, port 1.
- rs2_data  output  XLEN  read data, port 2.
- sb_set_enable  input  1  decode issues an instruction that will write sb_set_reg.
- sb_set_reg  input  5  destination register of the issued instruction.
- rs1_busy  output  1  rs1 has an older write still in flight that is not in WB this cycle.
- rs2_busy  output  1  rs2 has an older write still in flight that is not in WB this cycle.
- sb_overflow  output  1  sticky error flag: a set was attempted on a saturated counter.

Function
REQ-003 Storage SHALL be 31 registers x1..x31 of XLEN bits; x0 SHALL have no storage and SHALL always read 0.
REQ-004 On a rising clk edge with regif_wb_enable=1 and regif_wb_reg!=0, the register SHALL take regif_wb_data; writes to x0 SHALL be ignored.
REQ-005 rsN_data SHALL be combinational, with zero-cycle read latency.
REQ-006 Write-through bypass: when regif_wb_enable=1, regif_wb_reg==rsN_reg and rsN_reg!=0, rsN_data SHALL equal regif_wb_data in the same cycle.
REQ-007 Each register x1..x31 SHALL have a SB_CNT_W-bit pending counter cnt[r], range 0..3.
REQ-008 At a clock edge, for each r!=0, with set = (sb_set_enable and sb_set_reg==r) and clr = (regif_wb_enable and regif_wb_reg==r):
- set only: cnt+1.
- clr only: cnt-1.
- both, or neither: unchanged.
REQ-009 Set-only with cnt==3 SHALL leave cnt at 3 and SHALL set sb_overflow=1; sb_overflow SHALL stay 1 until reset.
REQ-010 Clr-only with cnt==0 SHALL leave cnt at 0 with no error, so unscoreboarded writes are legal.
REQ-011 sb_set_reg==0 SHALL be ignored.
REQ-012 rsN_busy SHALL be 0 when rsN_reg==0.
REQ-013 Otherwise, rsN_busy SHALL be 1 when cnt[rsN_reg]>=2, or when cnt[rsN_reg]==1 and the same-cycle WB write does not target rsN_reg; else 0.
REQ-014 rsN_busy SHALL depend on registered counts and the WB inputs only, never on sb_set_* in the same cycle.

Reset
REQ-015 reset low SHALL asynchronously clear all of x1..x31 to 0, all cnt to 0, and sb_overflow to 0.
REQ-016 Combinational outputs SHALL follow from the cleared state while reset is low: rsN_data=0 and rsN_busy=0 unless the bypass of REQ-006 is active.
REQ-017 Writes and sets presented while reset is low SHALL be lost; normal operation SHALL resume at the first rising edge after reset deasserts.

Structure
REQ-018 XLEN, NUM_REGS, SB_CNT_W and the 5-bit register-index width SHALL live in shared package rv32_pkg.
REQ-019 The per-register pending counter, with set/clr/saturate/overflow-pulse behaviour, SHALL be sub-module rv32_sb_counter, instantiated 31 times; the top SHALL OR the overflow pulses into sb_overflow.

Verification
REQ-020 A bench SHALL cover at least these directed scenarios:
- Write x5=0xDEADBEEF, then read rs1_reg=5 next cycle -> rs1_data=0xDEADBEEF.
- Same cycle: WB writes x7=0x12345678 and rs2_reg=7 -> rs2_data=0x12345678 combinationally; write x0=0xFFFFFFFF -> rs1_reg=0 reads 0.
- Set x3 twice, then WB x3 once -> rs1_busy=1; on second WB x3 cycle rs1_busy=0 with bypassed data; next cycle cnt=0.
- Same-cycle set and WB on x9 with cnt=1 -> cnt stays 1, rs1_busy(rs1_reg=9) =1 next cycle.
- Four sets on x4 with no WB -> cnt=3, sb_overflow=1 after the fourth edge; WB x4 -> cnt=2, sb_overflow still 1.
- Assert reset low mid-run with x1..x31 nonzero -> all reads 0, busy 0, sb_overflow 0 immediately, before any clk edge.
